imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the next-generation decode stage. Accepts one raw

---
 rtl/imm_gen_pipe_pkg.sv | 36 +++
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_gen_pipe_decode.sv | 115 +++++++++++
 rtl/imm_gen_pipe.sv | 83 ++++++++
 tb/tb_imm_gen_pipe.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared decode constants and the immediate-format tag for the immediate generator.
// Opcode/quadrant/funct3 values follow the RV32/RV64 base and C encodings.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] C_F3_ADDI4SPN  = 3'b000;
  localparam logic [2:0] C_F3_LW        = 3'b010;
  localparam logic [2:0] C_F3_SW        = 3'b110;
  localparam logic [2:0] C_F3_ADDI      = 3'b000;
  localparam logic [2:0] C_F3_JAL_ADDIW = 3'b001;
  localparam logic [2:0] C_F3_LI        = 3'b010;
  localparam logic [2:0] C_F3_LUI       = 3'b011;
  localparam logic [2:0] C_F3_MISC_ALU  = 3'b100;
  localparam logic [2:0] C_F3_J         = 3'b101;
  localparam logic [2:0] C_F3_BEQZ      = 3'b110;
  localparam logic [2:0] C_F3_BNEZ      = 3'b111;
  localparam logic [2:0] C_F3_SWSP      = 3'b110;

  typedef enum logic [3:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J,
    IMM_CI, IMM_CIU, IMM_CSS, IMM_CIW, IMM_CL, IMM_CJ, IMM_CB
  } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle; slave is the generator, master drives it.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  imm_type_e        imm_type;
  logic             imm_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, instr, in_tag, out_ready,
    input  in_ready, out_valid, imm, imm_type, imm_err, out_tag
  );

  modport slave (
    input  in_valid, instr, in_tag, out_ready,
    output in_ready, out_valid, imm, imm_type, imm_err, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> sign/zero-extended immediate, format tag and no-format flag.
// Unknown encodings resolve to imm=0/IMM_NONE, so no X ever leaves this block.
module imm_decode import imm_pkg::*; #(
  parameter int XLEN        = 32,
  parameter bit SUPPORT_RVC = 1'b1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            imm_err_o
);
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [1:0]      quad;
  logic [XLEN-1:0] imm_ci;
  logic [XLEN-1:0] imm_cj;
  logic [XLEN-1:0] imm_cl;

  assign opc  = instr_i[6:0];
  assign f3   = instr_i[15:13];
  assign quad = instr_i[1:0];

  // 6-bit signed field shared by C.ADDI/C.LI/C.ADDIW/C.ANDI
  assign imm_ci = XLEN'($signed({instr_i[12], instr_i[6:2]}));
  assign imm_cj = XLEN'($signed({instr_i[12], instr_i[8], instr_i[10:9], instr_i[6],
                                 instr_i[7], instr_i[2], instr_i[11], instr_i[5:3], 1'b0}));
  assign imm_cl = XLEN'({instr_i[5], instr_i[12:10], instr_i[6], 2'b00});

  always_comb begin
    imm_o      = '0;
    imm_type_o = IMM_NONE;
    if (quad == 2'b11) begin
      case (opc)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          imm_type_o = IMM_I;
          imm_o      = XLEN'($signed(instr_i[31:20]));
        end
        OPC_STORE: begin
          imm_type_o = IMM_S;
          imm_o      = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        end
        OPC_BRANCH: begin
          imm_type_o = IMM_B;
          imm_o      = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
        end
        OPC_JAL: begin
          imm_type_o = IMM_J;
          imm_o      = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
        end
        OPC_LUI, OPC_AUIPC: begin
          imm_type_o = IMM_U;
          imm_o      = XLEN'($signed({instr_i[31:12], 12'h000}));
        end
        default: ;
      endcase
    end else if (SUPPORT_RVC) begin
      case (quad)
        RVC_Q0: begin
          if (f3 == C_F3_ADDI4SPN) begin
            imm_type_o = IMM_CIW;
            imm_o      = XLEN'({instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00});
          end else if (f3 == C_F3_LW || f3 == C_F3_SW) begin
            imm_type_o = IMM_CL;
            imm_o      = imm_cl;
          end
        end
        RVC_Q1: begin
          case (f3)
            C_F3_ADDI, C_F3_LI: begin
              imm_type_o = IMM_CI;
              imm_o      = imm_ci;
            end
            // funct3=001 is C.JAL on RV32 but C.ADDIW on RV64
            C_F3_JAL_ADDIW: begin
              imm_type_o = (XLEN == 64) ? IMM_CI : IMM_CJ;
              imm_o      = (XLEN == 64) ? imm_ci : imm_cj;
            end
            C_F3_LUI: begin
              imm_type_o = IMM_CIU;
              if (instr_i[11:7] == 5'd2)
                imm_o = XLEN'($signed({instr_i[12], instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'h0}));
              else
                imm_o = XLEN'($signed({instr_i[12], instr_i[6:2], 12'h000}));
            end
            C_F3_MISC_ALU: begin
              if (instr_i[11:10] == 2'b10) begin
                imm_type_o = IMM_CB;
                imm_o      = imm_ci;
              end
            end
            C_F3_J: begin
              imm_type_o = IMM_CJ;
              imm_o      = imm_cj;
            end
            C_F3_BEQZ, C_F3_BNEZ: begin
              imm_type_o = IMM_CB;
              imm_o      = XLEN'($signed({instr_i[12], instr_i[6:5], instr_i[2], instr_i[11:10], instr_i[4:3], 1'b0}));
            end
            default: ;
          endcase
        end
        RVC_Q2: begin
          if (f3 == C_F3_SWSP) begin
            imm_type_o = IMM_CSS;
            imm_o      = XLEN'({instr_i[8:7], instr_i[12:9], 2'b00});
          end
        end
        default: ;
      endcase
    end
  end

  assign imm_err_o = (imm_type_o == IMM_NONE);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator pipe: 1-cycle latency, output register plus one skid entry.
// in_ready is registered (= skid empty); outputs hold while stalled; strict FIFO order.
module imm_gen_pipe import imm_pkg::*; #(
  parameter int XLEN        = 32,
  parameter bit SUPPORT_RVC = 1'b1,
  parameter int TAG_W       = 8
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        imm_type;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENT_RST = '{imm: '0, imm_type: IMM_NONE, err: 1'b0, tag: '0};

  entry_t out_q, out_d, skid_q, skid_d, new_ent;
  logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic   push, pop;

  imm_decode #(.XLEN(XLEN), .SUPPORT_RVC(SUPPORT_RVC)) u_dec (
    .instr_i    (bus.instr),
    .imm_o      (new_ent.imm),
    .imm_type_o (new_ent.imm_type),
    .imm_err_o  (new_ent.err)
  );
  assign new_ent.tag = bus.in_tag;

  assign push = bus.in_valid && !skid_vld_q;
  assign pop  = out_vld_q && bus.out_ready;

  // skid only fills while the output is stalled, so pop and push never both target it
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else if (push) begin
        out_d = new_ent;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push) begin
      if (out_vld_q) begin
        skid_d     = new_ent;
        skid_vld_d = 1'b1;
      end else begin
        out_d     = new_ent;
        out_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= ENT_RST;
      skid_q     <= ENT_RST;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready  = !skid_vld_q;
  assign bus.out_valid = out_vld_q;
  assign bus.imm       = out_q.imm;
  assign bus.imm_type  = out_q.imm_type;
  assign bus.imm_err   = out_q.err;
  assign bus.out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Three generator instances (RV32+C, RV64+C, RV32 without C) driven in lockstep.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bnr();

  imm_gen_pipe #(.XLEN(32), .SUPPORT_RVC(1'b1), .TAG_W(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .SUPPORT_RVC(1'b1), .TAG_W(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  imm_gen_pipe #(.XLEN(32), .SUPPORT_RVC(1'b0), .TAG_W(8)) unr (.clk(clk), .rst_n(rst_n), .bus(bnr));

  int checks = 0;
  int errors = 0;
  int xl[3] = '{32, 64, 32};
  bit rv[3] = '{1'b1, 1'b1, 1'b0};

  localparam logic [31:0] ADDI_M1 = 32'hFFF00093;

  typedef struct {
    logic [31:0] instr;
    int          dut;
    logic [63:0] imm;
    imm_type_e   typ;
    bit          err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  tag;
  } sb_t;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] tg, input logic ordy);
    b32.in_valid = v; b32.instr = ins; b32.in_tag = tg; b32.out_ready = ordy;
    b64.in_valid = v; b64.instr = ins; b64.in_tag = tg; b64.out_ready = ordy;
    bnr.in_valid = v; bnr.instr = ins; bnr.in_tag = tg; bnr.out_ready = ordy;
  endtask

  function automatic void get_out(input int d, output logic vld, output logic [63:0] imm,
                                  output imm_type_e t, output logic err, output logic [7:0] tg);
    case (d)
      0:       begin vld = b32.out_valid; imm = {32'h0, b32.imm}; t = b32.imm_type; err = b32.imm_err; tg = b32.out_tag; end
      1:       begin vld = b64.out_valid; imm = b64.imm;          t = b64.imm_type; err = b64.imm_err; tg = b64.out_tag; end
      default: begin vld = bnr.out_valid; imm = {32'h0, bnr.imm}; t = bnr.imm_type; err = bnr.imm_err; tg = bnr.out_tag; end
    endcase
  endfunction

  // Append instruction bits hi..lo (MSB first) to an accumulating immediate of width w.
  function automatic void cat(inout logic [63:0] v, inout int w, input logic [31:0] ins, input int hi, input int lo);
    int n;
    n = hi - lo + 1;
    v = (v << n) | ((64'(ins) >> lo) & ((64'd1 << n) - 64'd1));
    w += n;
  endfunction

  function automatic void zpad(inout logic [63:0] v, inout int w, input int n);
    v = v << n;
    w += n;
  endfunction

  // Reference: pick the format from the ISA rules, gather its fields, then extend arithmetically.
  task automatic model(input logic [31:0] ins, input int xlen, input bit rvc,
                       output logic [63:0] imm, output imm_type_e t, output bit err);
    logic [63:0] v;
    int w, q, f;
    bit sg;
    logic [6:0] op;
    v = '0; w = 0; sg = 1'b1; t = IMM_NONE;
    op = ins[6:0]; q = int'(ins[1:0]); f = int'(ins[15:13]);
    if (q == 3) begin
      if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin t = IMM_I; cat(v, w, ins, 31, 20); end
      else if (op == 7'h23) begin t = IMM_S; cat(v, w, ins, 31, 25); cat(v, w, ins, 11, 7); end
      else if (op == 7'h63) begin
        t = IMM_B; cat(v, w, ins, 31, 31); cat(v, w, ins, 7, 7); cat(v, w, ins, 30, 25); cat(v, w, ins, 11, 8); zpad(v, w, 1);
      end else if (op == 7'h6F) begin
        t = IMM_J; cat(v, w, ins, 31, 31); cat(v, w, ins, 19, 12); cat(v, w, ins, 20, 20); cat(v, w, ins, 30, 21); zpad(v, w, 1);
      end else if (op == 7'h37 || op == 7'h17) begin t = IMM_U; cat(v, w, ins, 31, 12); zpad(v, w, 12); end
    end else if (rvc) begin
      if (q == 1 && (f == 0 || f == 2 || (f == 1 && xlen == 64))) begin
        t = IMM_CI; cat(v, w, ins, 12, 12); cat(v, w, ins, 6, 2);
      end else if (q == 1 && (f == 5 || f == 1)) begin
        t = IMM_CJ; cat(v, w, ins, 12, 12); cat(v, w, ins, 8, 8); cat(v, w, ins, 10, 9); cat(v, w, ins, 6, 6);
        cat(v, w, ins, 7, 7); cat(v, w, ins, 2, 2); cat(v, w, ins, 11, 11); cat(v, w, ins, 5, 3); zpad(v, w, 1);
      end else if (q == 1 && f == 3 && ins[11:7] == 5'd2) begin
        t = IMM_CIU; cat(v, w, ins, 12, 12); cat(v, w, ins, 4, 3); cat(v, w, ins, 5, 5); cat(v, w, ins, 2, 2);
        cat(v, w, ins, 6, 6); zpad(v, w, 4);
      end else if (q == 1 && f == 3) begin
        t = IMM_CIU; cat(v, w, ins, 12, 12); cat(v, w, ins, 6, 2); zpad(v, w, 12);
      end else if (q == 1 && f == 4 && ins[11:10] == 2'b10) begin
        t = IMM_CB; cat(v, w, ins, 12, 12); cat(v, w, ins, 6, 2);
      end else if (q == 1 && f >= 6) begin
        t = IMM_CB; cat(v, w, ins, 12, 12); cat(v, w, ins, 6, 5); cat(v, w, ins, 2, 2); cat(v, w, ins, 11, 10);
        cat(v, w, ins, 4, 3); zpad(v, w, 1);
      end else if (q == 0 && f == 0) begin
        t = IMM_CIW; sg = 1'b0; cat(v, w, ins, 10, 7); cat(v, w, ins, 12, 11); cat(v, w, ins, 5, 5); cat(v, w, ins, 6, 6); zpad(v, w, 2);
      end else if (q == 0 && (f == 2 || f == 6)) begin
        t = IMM_CL; sg = 1'b0; cat(v, w, ins, 5, 5); cat(v, w, ins, 12, 10); cat(v, w, ins, 6, 6); zpad(v, w, 2);
      end else if (q == 2 && f == 6) begin
        t = IMM_CSS; sg = 1'b0; cat(v, w, ins, 8, 7); cat(v, w, ins, 12, 9); zpad(v, w, 2);
      end
    end
    if (t == IMM_NONE) v = '0;
    else if (sg && v[w-1]) v = v - (64'd1 << w);
    if (xlen == 32) v[63:32] = '0;
    imm = v;
    err = (t == IMM_NONE);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops[11];
    r   = $urandom;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h73, 7'h7F};
    if ($urandom_range(0, 1) == 0) return {r[31:7], ops[$urandom_range(0, 10)]};
    return {r[31:2], 2'($urandom_range(0, 2))};
  endfunction

  vec_t        vecs[16];
  sb_t         sb[$];
  logic [7:0]  got[$];
  logic        vld, err_o, cur_v, ordy, sent3, prev_stall;
  logic [63:0] imm_o, m_imm, prev_imm;
  imm_type_e   t_o, m_t;
  bit          m_err;
  logic [7:0]  tag_o, cur_tag, tag_ctr, prev_tag;
  logic [31:0] cur_ins;
  sb_t         e;

  initial begin
    vecs[0]  = '{32'hFFF00093, 0, 64'h00000000FFFFFFFF, IMM_I,    1'b0};
    vecs[1]  = '{32'hFE000EE3, 0, 64'h00000000FFFFFFFC, IMM_B,    1'b0};
    vecs[2]  = '{32'h001000EF, 0, 64'h0000000000000800, IMM_J,    1'b0};
    vecs[3]  = '{32'h800002B7, 1, 64'hFFFFFFFF80000000, IMM_U,    1'b0};
    vecs[4]  = '{32'h0000007F, 1, 64'h0,                IMM_NONE, 1'b1};
    vecs[5]  = '{32'h000050FD, 0, 64'h00000000FFFFFFFF, IMM_CI,   1'b0};
    vecs[6]  = '{32'h000050FD, 2, 64'h0,                IMM_NONE, 1'b1};
    vecs[7]  = '{32'hFE20AC23, 1, 64'hFFFFFFFFFFFFFFF8, IMM_S,    1'b0};
    vecs[8]  = '{32'h0000BFFD, 0, 64'h00000000FFFFFFFE, IMM_CJ,   1'b0};
    vecs[9]  = '{32'h00001FE0, 0, 64'h00000000000003FC, IMM_CIW,  1'b0};
    vecs[10] = '{32'h00003FFD, 0, 64'h00000000FFFFFFFE, IMM_CJ,   1'b0};
    vecs[11] = '{32'h00003FFD, 1, 64'hFFFFFFFFFFFFFFFF, IMM_CI,   1'b0};
    vecs[12] = '{32'h00008005, 0, 64'h0,                IMM_NONE, 1'b1};
    vecs[13] = '{32'h00007081, 0, 64'h00000000FFFE0000, IMM_CIU,  1'b0};
    vecs[14] = '{32'h12345017, 1, 64'h0000000012345000, IMM_U,    1'b0};
    vecs[15] = '{32'h00000033, 0, 64'h0,                IMM_NONE, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_imm32", 64'(b32.imm), 64'd0);
    chk("rst_imm64", b64.imm, 64'd0);
    chk("rst_type", 64'(b32.imm_type), 64'(IMM_NONE));
    chk("rst_err", 64'(b32.imm_err), 64'd0);
    chk("rst_tag", 64'(b32.out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].instr, 8'(i + 16), 1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 8'h0, 1'b1);
      #1;
      get_out(vecs[i].dut, vld, imm_o, t_o, err_o, tag_o);
      chk($sformatf("vec%0d_valid", i), 64'(vld), 64'd1);
      chk($sformatf("vec%0d_imm", i), imm_o, vecs[i].imm);
      chk($sformatf("vec%0d_type", i), 64'(t_o), 64'(vecs[i].typ));
      chk($sformatf("vec%0d_err", i), 64'(err_o), 64'(vecs[i].err));
      chk($sformatf("vec%0d_tag", i), 64'(tag_o), 64'(i + 16));
    end

    // Backpressure: tags 1,2 fill output+skid, tag 3 waits for release.
    @(negedge clk);
    drive(1'b1, ADDI_M1, 8'd1, 1'b0);
    #1 chk("bp_ready_t1", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    drive(1'b1, ADDI_M1, 8'd2, 1'b0);
    #1;
    chk("bp_ready_t2", 64'(b32.in_ready), 64'd1);
    chk("bp_out_t1", 64'(b32.out_tag), 64'd1);
    @(negedge clk);
    drive(1'b1, ADDI_M1, 8'd3, 1'b0);
    #1 chk("bp_ready_full", 64'(b32.in_ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("bp_hold_ready", 64'(b32.in_ready), 64'd0);
      chk("bp_hold_tag", 64'(b32.out_tag), 64'd1);
    end
    sent3 = 1'b0;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(!sent3, ADDI_M1, 8'd3, 1'b1);
      #1;
      if (b32.out_valid) got.push_back(b32.out_tag);
      if (!sent3 && b32.in_ready) sent3 = 1'b1;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'(k + 1));

    // Reset with both entries occupied.
    @(negedge clk);
    drive(1'b1, ADDI_M1, 8'd5, 1'b0);
    @(negedge clk);
    drive(1'b1, ADDI_M1, 8'd6, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 8'h0, 1'b0);
    #1 chk("rs_full", 64'(b32.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rs_in_ready", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1 chk("rs_no_stale", 64'(b32.out_valid), 64'd0);
    end

    // Random traffic against the reference model.
    cur_v = 1'b0; cur_ins = '0; cur_tag = '0; tag_ctr = 8'd100; prev_stall = 1'b0;
    prev_imm = '0; prev_tag = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!cur_v && $urandom_range(0, 3) != 0) begin
        cur_v = 1'b1; cur_ins = rand_instr(); cur_tag = tag_ctr; tag_ctr++;
      end
      ordy = (c >= 380) || ($urandom_range(0, 9) < 7);
      if (c >= 380) cur_v = cur_v && (sb.size() == 0 && 1'b0);
      drive(cur_v, cur_ins, cur_tag, ordy);
      #1;
      if (prev_stall) begin
        chk("hold_valid", 64'(b32.out_valid), 64'd1);
        chk("hold_tag", 64'(b32.out_tag), 64'(prev_tag));
        chk("hold_imm", 64'(b32.imm), prev_imm);
      end
      prev_stall = b32.out_valid && !ordy;
      prev_tag   = b32.out_tag;
      prev_imm   = 64'(b32.imm);
      if (b32.out_valid && ordy) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          for (int d = 0; d < 3; d++) begin
            model(e.instr, xl[d], rv[d], m_imm, m_t, m_err);
            get_out(d, vld, imm_o, t_o, err_o, tag_o);
            chk($sformatf("rnd_d%0d_valid", d), 64'(vld), 64'd1);
            chk($sformatf("rnd_d%0d_imm_%h", d, e.instr), imm_o, m_imm);
            chk($sformatf("rnd_d%0d_type_%h", d, e.instr), 64'(t_o), 64'(m_t));
            chk($sformatf("rnd_d%0d_err_%h", d, e.instr), 64'(err_o), 64'(m_err));
            chk($sformatf("rnd_d%0d_tag", d), 64'(tag_o), 64'(e.tag));
          end
        end
      end
      if (cur_v && b32.in_ready) begin
        sb.push_back('{cur_ins, cur_tag});
        cur_v = 1'b0;
      end
    end
    chk("rnd_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
